// File: rtl/rcv_bit_timer.sv
// USB receive bit timer: recovers the bit-centre sample point from line edges,
// drops stuffed bits and strobes unstuffed data bits and completed bytes to
// the receive shift register.
module rcv_bit_timer #(
  parameter int CLKS_PER_BIT  = 8,
  parameter int SAMPLE_POINT  = 3,
  parameter int BITS_PER_BYTE = 8,
  parameter int MAX_ONES      = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rcving,
  input  logic                             d_edge,
  input  logic                             d_orig,
  output logic                             shift_enable,
  output logic                             rcv_bit,
  output logic                             byte_received,
  output logic                             stuff_err,
  output logic [$clog2(BITS_PER_BYTE)-1:0] bit_count
);

  localparam int PW  = $clog2(CLKS_PER_BIT);
  localparam int OW  = $clog2(MAX_ONES + 1);
  localparam int BCW = $clog2(BITS_PER_BYTE);

  localparam logic [PW-1:0]  PH_LAST  = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0]  PH_SAMP  = PW'(SAMPLE_POINT);
  localparam logic [OW-1:0]  ONES_MAX = OW'(MAX_ONES);
  localparam logic [BCW-1:0] BC_LAST  = BCW'(BITS_PER_BYTE - 1);

  logic [PW-1:0]  r_phase, w_phase_nxt;
  logic [OW-1:0]  r_ones, w_ones_nxt;
  logic [BCW-1:0] r_bit_count, w_bit_count_nxt;
  logic           r_shift, r_rcv_bit, r_byte, r_stuff_err;

  logic w_sample, w_stuff, w_data, w_last;

  // The sample point is the current phase; an edge in the same cycle still
  // samples, it only restarts the phase for the next bit.
  assign w_sample = rcving && (r_phase == PH_SAMP);
  assign w_stuff  = w_sample && (r_ones == ONES_MAX);
  assign w_data   = w_sample && !w_stuff;
  assign w_last   = (r_bit_count == BC_LAST);

  // Next-state for phase, ones run length and bit position in the byte.
  // The edge cycle counts as phase 0, so the phase after an edge is 1.
  always_comb begin
    w_phase_nxt     = r_phase;
    w_ones_nxt      = r_ones;
    w_bit_count_nxt = r_bit_count;
    if (!rcving) begin
      w_phase_nxt     = '0;
      w_ones_nxt      = '0;
      w_bit_count_nxt = '0;
    end else begin
      if (d_edge)                 w_phase_nxt = PW'(1);
      else if (r_phase == PH_LAST) w_phase_nxt = '0;
      else                        w_phase_nxt = r_phase + PW'(1);

      if (w_stuff) begin
        w_ones_nxt = '0;
      end else if (w_data) begin
        if (!d_orig)                 w_ones_nxt = '0;
        else if (r_ones != ONES_MAX) w_ones_nxt = r_ones + OW'(1);
        w_bit_count_nxt = w_last ? '0 : r_bit_count + BCW'(1);
      end
    end
  end

  // State and registered strobes; strobes are high only in the cycle after the sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase     <= '0;
      r_ones      <= '0;
      r_bit_count <= '0;
      r_shift     <= 1'b0;
      r_rcv_bit   <= 1'b0;
      r_byte      <= 1'b0;
      r_stuff_err <= 1'b0;
    end else begin
      r_phase     <= w_phase_nxt;
      r_ones      <= w_ones_nxt;
      r_bit_count <= w_bit_count_nxt;
      r_shift     <= w_data;
      r_rcv_bit   <= w_data && d_orig;
      r_byte      <= w_data && w_last;
      r_stuff_err <= w_stuff && d_orig;
    end
  end

  assign shift_enable  = r_shift;
  assign rcv_bit       = r_rcv_bit;
  assign byte_received = r_byte;
  assign stuff_err     = r_stuff_err;
  assign bit_count     = r_bit_count;

endmodule

// File: tb/tb_rcv_bit_timer.sv
// Bench for rcv_bit_timer: per-bit vector tables with expected strobes pushed
// to a scoreboard and compared in the cycle after each bit's sample point.
module tb_rcv_bit_timer;

  logic clk = 1'b0;
  logic rst, rcving, d_edge, d_orig;
  logic shift_enable, rcv_bit, byte_received, stuff_err;
  logic [2:0] bit_count;

  rcv_bit_timer dut (
    .clk(clk), .rst(rst), .rcving(rcving), .d_edge(d_edge), .d_orig(d_orig),
    .shift_enable(shift_enable), .rcv_bit(rcv_bit), .byte_received(byte_received),
    .stuff_err(stuff_err), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit d; bit edg; int len;
    bit se; bit rb; bit err; bit br; logic [2:0] bc;
  } vec_t;

  typedef struct {
    int due; bit se; bit rb; bit err; bit br; logic [2:0] bc;
  } exp_t;

  int   tests = 0, fails = 0;
  int   cyc = 0;
  bit   chk_en = 1'b0;
  logic [2:0] last_bc = '0;
  exp_t exp_q[$];
  vec_t pkt1[$], pkt2[$], pkt3[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(bit d, bit edg, int len, bit se, bit rb, bit err,
                              bit br, logic [2:0] bc);
    vec_t v;
    v.d = d; v.edg = edg; v.len = len;
    v.se = se; v.rb = rb; v.err = err; v.br = br; v.bc = bc;
    return v;
  endfunction

  // Scoreboard: compare due entries, otherwise strobes must be idle and bit_count held.
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        chk("shift_enable", shift_enable, e.se);
        if (e.se) chk("rcv_bit", rcv_bit, e.rb);
        chk("stuff_err", stuff_err, e.err);
        chk("byte_received", byte_received, e.br);
        chk("bit_count", bit_count, e.bc);
        last_bc = e.bc;
      end else begin
        chk("idle_shift", shift_enable, 0);
        chk("idle_stuff_err", stuff_err, 0);
        chk("idle_byte", byte_received, 0);
        chk("held_bit_count", bit_count, last_bc);
      end
    end
  end

  // One bit period starting at effective phase 0; its sample lands 3 cycles in,
  // the registered result one cycle later.
  task automatic drive_bit(vec_t v);
    exp_t e;
    e.due = cyc + 4; e.se = v.se; e.rb = v.rb; e.err = v.err; e.br = v.br; e.bc = v.bc;
    exp_q.push_back(e);
    for (int k = 0; k < v.len; k++) begin
      d_edge = (k == 0) && v.edg;
      d_orig = v.d;
      @(posedge clk); #1;
    end
    d_edge = 1'b0;
  endtask

  task automatic idle(int n);
    exp_t e;
    rcving = 1'b0;
    e.due = cyc + 1; e.se = 0; e.rb = 0; e.err = 0; e.br = 0; e.bc = '0;
    exp_q.push_back(e);
    for (int k = 0; k < n; k++) begin
      d_edge = (k == 1);
      d_orig = 1'b1;
      @(posedge clk); #1;
    end
    d_edge = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Packet 1: a zero byte, valid stuff, stuff error, partial byte then abort.
    for (int i = 0; i < 7; i++) pkt1.push_back(mk(0, 1, 8, 1, 0, 0, 0, 3'(i + 1)));
    pkt1.push_back(mk(0, 1, 8, 1, 0, 0, 1, 0));
    for (int i = 0; i < 6; i++) pkt1.push_back(mk(1, 0, 8, 1, 1, 0, 0, 3'(i + 1)));
    pkt1.push_back(mk(0, 1, 8, 0, 0, 0, 0, 6));          // stuff bit, dropped
    pkt1.push_back(mk(0, 1, 8, 1, 0, 0, 0, 7));
    pkt1.push_back(mk(1, 0, 8, 1, 1, 0, 1, 0));
    for (int i = 0; i < 5; i++) pkt1.push_back(mk(1, 0, 8, 1, 1, 0, 0, 3'(i + 1)));
    pkt1.push_back(mk(1, 0, 8, 0, 0, 1, 0, 5));          // 7th one: stuff error
    pkt1.push_back(mk(1, 0, 8, 1, 1, 0, 0, 6));          // run restarted at 1
    pkt1.push_back(mk(0, 1, 8, 1, 0, 0, 0, 7));
    pkt1.push_back(mk(0, 1, 8, 1, 0, 0, 1, 0));
    for (int i = 0; i < 4; i++) pkt1.push_back(mk(0, 1, 8, 1, 0, 0, 0, 3'(i + 1)));
    pkt1.push_back(mk(1, 0, 8, 1, 1, 0, 0, 5));          // abort with bit_count=5, ones=1
    // Packet 2: resync at phase 6, edge on the sample cycle, ones run cleared by abort.
    pkt2.push_back(mk(1, 1, 8, 1, 1, 0, 0, 1));
    pkt2.push_back(mk(1, 0, 6, 1, 1, 0, 0, 2));
    pkt2.push_back(mk(1, 1, 3, 1, 1, 0, 0, 3));
    pkt2.push_back(mk(1, 1, 8, 1, 1, 0, 0, 4));
    pkt2.push_back(mk(1, 0, 8, 1, 1, 0, 0, 5));
    pkt2.push_back(mk(1, 0, 8, 1, 1, 0, 0, 6));
    pkt2.push_back(mk(0, 1, 8, 0, 0, 0, 0, 6));
    pkt2.push_back(mk(0, 1, 8, 1, 0, 0, 0, 7));
    pkt2.push_back(mk(0, 1, 8, 1, 0, 0, 1, 0));
    // Packet 3: cut short by an asynchronous reset.
    for (int i = 0; i < 3; i++) pkt3.push_back(mk(0, 1, 8, 1, 0, 0, 0, 3'(i + 1)));

    // Reset held with live traffic: outputs stay 0.
    rst = 1'b1; rcving = 1'b1; d_edge = 1'b0; d_orig = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      d_edge = 1'($urandom_range(0, 1)); d_orig = 1'($urandom_range(0, 1));
      #3;
      chk("rst_shift", shift_enable, 0);
      chk("rst_bit_count", bit_count, 0);
    end
    chk("rst_outs", {rcv_bit, byte_received, stuff_err}, 0);
    @(posedge clk); #1;
    rst = 1'b0; rcving = 1'b0; d_edge = 1'b0;
    chk_en = 1'b1;
    repeat (3) begin @(posedge clk); #1; end

    rcving = 1'b1;
    foreach (pkt1[i]) drive_bit(pkt1[i]);
    idle(4);
    rcving = 1'b1;
    foreach (pkt2[i]) drive_bit(pkt2[i]);
    idle(3);
    rcving = 1'b1;
    foreach (pkt3[i]) drive_bit(pkt3[i]);
    chk("queue_drained", exp_q.size(), 0);

    // Asynchronous reset mid-packet, between clock edges.
    d_edge = 1'b1;
    @(negedge clk);
    chk_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_bit_count", bit_count, 0);
    chk("async_rst_strobes", {shift_enable, rcv_bit, byte_received, stuff_err}, 0);
    @(posedge clk); #1;
    d_edge = 1'b0; rst = 1'b0; rcving = 1'b0;
    last_bc = '0; exp_q.delete();
    chk_en = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
